project1_task2_driver: RTL and testbench



---
 rtl/project1_task2_pkg.sv | 46 ++++
 rtl/lfsr8.sv | 35 +++
 rtl/project1_task2_driver.sv | 171 +++++++++++++++++
 tb/tb_project1_task2_driver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/project1_task2_pkg.sv
// Shared types, constants and golden-model helpers for the project1 task2 driver.
package project1_task2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Feedback taps q[7]^q[5]^q[4]^q[3]
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // Evaluates the task2 combinational cone; returns {j, f}
  function automatic logic [1:0] task2_eval(input logic a, input logic b,
                                            input logic c, input logic d,
                                            input logic k);
    logic h;
    logic g;
    logic n;
    logic f;
    h = ~(a | b);
    g = b ^ c;
    n = ~(c & d);
    f = k ? g : h;
    return {n | f, f};
  endfunction

  function automatic logic f_expected(input logic a, input logic b,
                                      input logic c, input logic d,
                                      input logic k);
    logic [1:0] r;
    r = task2_eval(a, b, c, d, k);
    return r[0];
  endfunction

  function automatic logic j_next(input logic a, input logic b,
                                  input logic c, input logic d,
                                  input logic k);
    logic [1:0] r;
    r = task2_eval(a, b, c, d, k);
    return r[1];
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, left shifting, with synchronous load and enable.
module lfsr8
  import project1_task2_pkg::*;
#(
  parameter logic [7:0]  SEED  = DEFAULT_SEED,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_q
);

  // An all-zero seed would lock the register, so it is replaced by 1
  localparam logic [7:0] LOAD_VAL = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);
  assign o_q  = r_q[OUT_W-1:0];

  // Shift register: load has priority over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= LOAD_VAL;
    end else if (i_load) begin
      r_q <= LOAD_VAL;
    end else if (i_en) begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

endmodule

// File: rtl/project1_task2_driver.sv
// Stimulus driver and response checker for the task2 a/b/c/d -> f circuit.
// Optional macro PROJECT1_TASK2_DRIVER_MISMATCH_LOG_EN adds first-mismatch
// capture ports first_err_idx / first_err_vec.
module project1_task2_driver
  import project1_task2_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [7:0]  SEED        = DEFAULT_SEED,
  parameter int unsigned SYNC_CYCLES = 2,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               f_obs,
  output logic                               a,
  output logic                               b,
  output logic                               c,
  output logic                               d,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [ERR_W-1:0]                   err_count,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count
`ifdef PROJECT1_TASK2_DRIVER_MISMATCH_LOG_EN
  ,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   first_err_idx,
  output logic [3:0]                         first_err_vec
`endif
);

  localparam int unsigned VC_W = $clog2(NUM_VECTORS + 1);
  localparam int unsigned SC_W = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SC_W-1:0]  r_sync_cnt;
  logic             r_k;
  logic [3:0]       w_lfsr_nib;
  logic             w_sync_last;
  logic             w_run_last;
  logic             w_start_run;
  logic             w_lfsr_en;
  logic             w_cmp;
  logic             w_f_exp;
  logic             w_j;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_inc;
  logic [ERR_W-1:0] w_err_nxt;

  lfsr8 #(
    .SEED  (SEED),
    .OUT_W (4)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start_run),
    .i_en   (w_lfsr_en),
    .o_q    (w_lfsr_nib)
  );

  assign w_sync_last = (r_sync_cnt == SC_W'(SYNC_CYCLES - 1));
  assign w_run_last  = (vec_count == VC_W'(NUM_VECTORS - 1));
  assign w_f_exp     = f_expected(a, b, c, d, r_k);
  assign w_j         = j_next(a, b, c, d, r_k);
  assign w_mismatch  = w_cmp && (f_obs != w_f_exp);
  assign w_err_inc   = (&err_count) ? err_count : err_count + ERR_W'(1);
  assign w_err_nxt   = w_mismatch ? w_err_inc : err_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured when not busy
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start)       w_state_nxt = ST_SYNC;
      ST_SYNC:          if (w_sync_last) w_state_nxt = ST_RUN;
      ST_RUN:           if (w_run_last)  w_state_nxt = ST_DONE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath and LFSR
  always_comb begin
    w_start_run = 1'b0;
    w_lfsr_en   = 1'b0;
    w_cmp       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: w_start_run = start;
      ST_SYNC:          w_lfsr_en   = w_sync_last;
      ST_RUN: begin
        w_cmp     = 1'b1;
        w_lfsr_en = ~w_run_last;
      end
      default: ;
    endcase
  end

  // Stimulus, golden-model k, counters and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {a, b, c, d} <= 4'b0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      vec_count    <= '0;
      r_sync_cnt   <= '0;
      r_k          <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_run) begin
            {a, b, c, d} <= 4'b0000;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            vec_count    <= '0;
            r_sync_cnt   <= '0;
            r_k          <= 1'b1;
          end
        end
        ST_SYNC: begin
          r_sync_cnt <= r_sync_cnt + SC_W'(1);
          r_k        <= 1'b1;
          if (w_sync_last) begin
            {a, b, c, d} <= w_lfsr_nib;
          end
        end
        ST_RUN: begin
          err_count <= w_err_nxt;
          vec_count <= vec_count + VC_W'(1);
          r_k       <= w_j;
          if (w_run_last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (w_err_nxt == '0);
          end else begin
            {a, b, c, d} <= w_lfsr_nib;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PROJECT1_TASK2_DRIVER_MISMATCH_LOG_EN
  // Capture index and vector of the first mismatch; err_count==0 marks "none yet"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_idx <= '0;
      first_err_vec <= 4'b0000;
    end else if (w_start_run) begin
      first_err_idx <= '0;
      first_err_vec <= 4'b0000;
    end else if (w_mismatch && (err_count == '0)) begin
      first_err_idx <= vec_count;
      first_err_vec <= {a, b, c, d};
    end
  end
`endif

endmodule

// File: tb/tb_project1_task2_driver.sv
// Randomized self-checking bench for project1_task2_driver against a
// cycle-count based reference model and an ideal/faulty task2 circuit.
module tb_project1_task2_driver;
  import project1_task2_pkg::*;

  localparam int unsigned N    = 64;
  localparam int unsigned S    = 2;
  localparam int unsigned EW   = 6;
  localparam int unsigned VCW  = $clog2(N + 1);
  localparam int          EMAX = (1 << EW) - 1;
  localparam logic [7:0]  TB_SEED = 8'hA5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           f_obs;
  logic           a, b, c, d;
  logic           busy, done, pass;
  logic [EW-1:0]  err_count;
  logic [VCW-1:0] vec_count;
`ifdef PROJECT1_TASK2_DRIVER_MISMATCH_LOG_EN
  logic [VCW-1:0] first_err_idx;
  logic [3:0]     first_err_vec;
`endif

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  project1_task2_driver #(
    .NUM_VECTORS (N),
    .SEED        (TB_SEED),
    .SYNC_CYCLES (S),
    .ERR_W       (EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .f_obs     (f_obs),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .vec_count (vec_count)
`ifdef PROJECT1_TASK2_DRIVER_MISMATCH_LOG_EN
    ,
    .first_err_idx (first_err_idx),
    .first_err_vec (first_err_vec)
`endif
  );

  // Bench golden: v = {a,b,c,d}
  function automatic logic gold_f(input logic [3:0] v, input logic k);
    if (k) return v[2] ^ v[1];
    return !(v[3] || v[2]);
  endfunction

  function automatic logic gold_j(input logic [3:0] v, input logic k);
    return !(v[1] && v[0]) || gold_f(v, k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Task2 circuit driven by the DUT, with a fault overlay on f
  int   fault_mode = 0;      // 0 ideal, 1 stuck-at-0, 2 inverted, 3 flip mask
  bit   f_mask [N];
  logic t2_k;
  logic t2_f;

  assign t2_f = t2_k ? (b ^ c) : ~(a | b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t2_k <= 1'b1;
    else        t2_k <= ~(c & d) | t2_f;
  end

  // Reference model: runs are described by edges elapsed since the start edge
  bit         m_started = 1'b0;
  int         m_t = 0;
  logic [3:0] m_vec [N];
  bit         m_mm  [N];

  always_comb begin
    f_obs = t2_f;
    case (fault_mode)
      1: f_obs = 1'b0;
      2: f_obs = ~t2_f;
      3: if (m_started && m_t >= S && m_t < S + N) f_obs = t2_f ^ f_mask[m_t - S];
      default: ;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;
      m_t       <= 0;
    end else if (start && !(m_started && m_t < S + N)) begin
      logic [7:0] lf;
      logic       k;
      logic       fe;
      lf = (TB_SEED == 8'h00) ? 8'h01 : TB_SEED;
      k  = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_vec[i] = lf[3:0];
        fe = gold_f(lf[3:0], k);
        k  = gold_j(lf[3:0], k);
        lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        case (fault_mode)
          1:       m_mm[i] = fe;
          2:       m_mm[i] = 1'b1;
          3:       m_mm[i] = f_mask[i];
          default: m_mm[i] = 1'b0;
        endcase
      end
      m_started <= 1'b1;
      m_t       <= 0;
    end else if (m_started && m_t < S + N) begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    int         vc_e;
    int         cnt;
    int         fi;
    logic [3:0] ab_e;
    logic       busy_e, done_e;
    vc_e = 0; ab_e = 4'h0; busy_e = 1'b0; done_e = 1'b0; cnt = 0; fi = -1;
    if (m_started) begin
      if (m_t < S) begin
        busy_e = 1'b1;
      end else if (m_t < S + N) begin
        busy_e = 1'b1;
        vc_e   = m_t - S;
        ab_e   = m_vec[vc_e];
      end else begin
        done_e = 1'b1;
        vc_e   = N;
        ab_e   = m_vec[N-1];
      end
      for (int i = 0; i < vc_e; i++) begin
        if (m_mm[i]) begin
          if (fi < 0) fi = i;
          cnt++;
        end
      end
    end
    check("abcd", 32'({a, b, c, d}), 32'(ab_e));
    check("busy", 32'(busy), 32'(busy_e));
    check("done", 32'(done), 32'(done_e));
    check("pass", 32'(pass), 32'(done_e && cnt == 0));
    check("err_count", 32'(err_count), 32'((cnt > EMAX) ? EMAX : cnt));
    check("vec_count", 32'(vec_count), 32'(vc_e));
`ifdef PROJECT1_TASK2_DRIVER_MISMATCH_LOG_EN
    check("first_err_idx", 32'(first_err_idx), 32'((fi < 0) ? 0 : fi));
    check("first_err_vec", 32'(first_err_vec), 32'((fi < 0) ? 4'h0 : m_vec[fi]));
`endif
  end

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); #1 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Pin the bench golden with hand-computed values
    check("pin_f_5_k1", 32'(gold_f(4'h5, 1'b1)), 32'd1);
    check("pin_f_0_k0", 32'(gold_f(4'h0, 1'b0)), 32'd1);
    check("pin_f_8_k0", 32'(gold_f(4'h8, 1'b0)), 32'd0);
    check("pin_f_6_k1", 32'(gold_f(4'h6, 1'b1)), 32'd0);
    check("pin_j_3_k0", 32'(gold_j(4'h3, 1'b0)), 32'd1);
    check("pin_j_B_k0", 32'(gold_j(4'hB, 1'b0)), 32'd0);
    // Package helpers against the bench golden, exhaustively
    for (int i = 0; i < 32; i++) begin
      logic [4:0] x;
      x = 5'(i);
      check("pkg_f_expected", 32'(f_expected(x[3], x[2], x[1], x[0], x[4])), 32'(gold_f(x[3:0], x[4])));
      check("pkg_j_next",     32'(j_next(x[3], x[2], x[1], x[0], x[4])),     32'(gold_j(x[3:0], x[4])));
    end

    // Reset, then an ideal run with first vectors pinned and an ignored start
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fault_mode = 0;
    pulse_start();
    repeat (S) @(negedge clk);
    check("first_vec_A5", 32'({a, b, c, d}), 32'h5);
    @(negedge clk);
    check("second_vec_A5", 32'({a, b, c, d}), 32'hA);
    repeat (9) @(negedge clk);
    pulse_start();
    wait_done();
    check("ideal_vec_count", 32'(vec_count), 32'd64);
    check("ideal_pass", 32'(pass), 32'd1);
    check("ideal_err", 32'(err_count), 32'd0);

    // Restart from DONE reproduces the sequence
    pulse_start();
    repeat (S) @(negedge clk);
    check("restart_first_vec", 32'({a, b, c, d}), 32'h5);
    wait_done();

    // Stuck-at-0 observed output
    fault_mode = 1;
    pulse_start();
    wait_done();
    check("stuck_nonzero", 32'(err_count != '0), 32'd1);
    check("stuck_pass", 32'(pass), 32'd0);

    // Inverted output saturates the counter
    fault_mode = 2;
    pulse_start();
    wait_done();
    check("sat_err", 32'(err_count), 32'(EMAX));
    check("sat_pass", 32'(pass), 32'd0);

    // Single flip at vector 5
    fault_mode = 3;
    for (int i = 0; i < N; i++) f_mask[i] = (i == 5);
    pulse_start();
    wait_done();
    check("flip5_err", 32'(err_count), 32'd1);
`ifdef PROJECT1_TASK2_DRIVER_MISMATCH_LOG_EN
    check("flip5_idx", 32'(first_err_idx), 32'd5);
`endif

    // Reset mid-run, then a clean run
    fault_mode = 0;
    pulse_start();
    repeat (S + 29) @(negedge clk);
    do_reset(2);
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_vc", 32'(vec_count), 32'd0);
    pulse_start();
    wait_done();
    check("post_reset_pass", 32'(pass), 32'd1);

    // Randomized runs: fault mode, flip masks, stray starts, resets
    for (int r = 0; r < 10; r++) begin
      fault_mode = int'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) f_mask[i] = ($urandom_range(0, 7) == 0);
      pulse_start();
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        do_reset($urandom_range(1, 3));
        pulse_start();
      end else begin
        pulse_start();
      end
      wait_done();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
